execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  ID/EX pipeline register plus execute-stage datapath for the 5-stage RV32I core.
//  Captures decode outputs, including ALUControlD from the ALU decoder, and applies
//  forwarding muxes. Computes the ALU result, branch decision and branch/jump target.
//  Feeds the EX/MEM register and the hazard unit (Rs1E/Rs2E/RdE).
// PARAMETERS
//  XLEN      32   datapath width
//  REG_AW    5    register-index width
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous active-high reset
//  StallE       in   1      hold ID/EX contents
//  FlushE       in   1      load bubble into ID/EX
//  RegWriteD    in   1      decode control
//  ResultSrcD   in   2      decode control
//  MemWriteD    in   1      decode control
//  JumpD        in   1      decode control
//  BranchD      in   1      decode control
//  ALUSrcD      in   1      decode control
//  ALUControlD  in   4      ALU op code (0000 ADD ... 1001 SLTU)
//  funct3D      in   3      branch type
//  RD1D,RD2D    in   XLEN   register-file read data
//  ImmExtD      in   XLEN   sign-extended immediate
//  PCD,PCPlus4D in   XLEN   PC and PC+4
//  Rs1D,Rs2D,RdD in  REG_AW register indices
//  ForwardAE    in   2      SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM
//  ForwardBE    in   2      same for RD2E
//  ResultW      in   XLEN   writeback value
//  ALUResultM   in   XLEN   memory-stage ALU value
//  ALUResultE   out  XLEN   ALU output
//  WriteDataE   out  XLEN   forwarded RD2 (store data)
//  PCTargetE    out  XLEN   PCE + ImmExtE
//  PCSrcE       out  1      JumpE | (BranchE & taken)
//  RegWriteE,ResultSrcE[2],MemWriteE out  registered controls to EX/MEM
//  RdE,Rs1E,Rs2E out  REG_AW  registered indices to hazard unit
//  PCPlus4E     out  XLEN   registered PC+4
// BEHAVIOUR
//  - Register update on posedge clk. Priority: rst > FlushE > StallE > load.
//  - rst or FlushE: every ID/EX field cleared to 0. This is the bubble:
//    RegWriteE=0, MemWriteE=0, PCSrcE=0, ALUControlE=0000, indices 0.
//  - FlushE wins over a simultaneous StallE. StallE=1 holds all fields unchanged.
//  - Latency: D inputs are visible at E outputs after 1 edge.
//    All E-stage outputs are combinational from the register and forward inputs.
//  - SrcA = mux(ForwardAE). WriteDataE = mux(ForwardBE).
//    SrcB = ALUSrcE ? ImmExtE : WriteDataE. Forward code 11 selects RD*E.
//  - ALU, all arithmetic mod 2^XLEN:
//    0000 A+B; 0001 A-B; 0010 A^B; 0011 A&B; 0100 A|B;
//    0101 A<<B[4:0]; 0110 A>>B[4:0] logical; 0111 A>>>B[4:0] arithmetic;
//    1000 signed A<B ? 1:0; 1001 unsigned A<B ? 1:0; 1010-1111 -> 0.
//  - Branch compare uses SrcA vs forwarded RD2 (not SrcB). It is independent of ALUControlE.
//    funct3 000 eq; 001 ne; 100 lt signed; 101 ge signed; 110 ltu; 111 geu.
//    funct3 010/011 -> not taken.
//  - PCTargetE = PCE + ImmExtE; wraps past 0xFFFFFFFF.
//  - Shift amounts use only SrcB[4:0]; upper bits ignored.
//  - Reset mid-stall clears the register; after rst deasserts, normal load resumes next edge.
// STRUCTURE
//  - riscv_pkg: ALU_ADD..ALU_SLTU localparams (4-bit), FWD_REG/FWD_WB/FWD_MEM codes,
//    BR_* funct3 codes.
//  - Sub-module alu_core: combinational SrcA/SrcB/ALUControl -> ALUResult.
//  - ID/EX register, forwarding muxes and branch logic stay in execute_stage.
// TESTING
//  1. RD1D=5, RD2D=7, ALUControlD=0000, ALUSrcD=0, Fwd=00
//     -> after 1 edge ALUResultE=12.
//     With ALUControlD=0001 -> 0xFFFFFFFE.
//  2. SrcA=0x80000000, ImmExtD=0x24, ALUSrcD=1:
//     0111 -> 0xF8000000; 0110 -> 0x08000000 (shamt 4).
//  3. ForwardAE=10, ALUResultM=0x100, ForwardBE=01, ResultW=0x23, ADD
//     -> ALUResultE=0x123, WriteDataE=0x23.
//  4. RD1D=0xFFFFFFFF, RD2D=1, BranchD=1, funct3D=100 -> PCSrcE=1.
//     funct3D=110 -> PCSrcE=0. PCD=0x1000, ImmExtD=0xFFFFFFF0 -> PCTargetE=0xFF0.
//  5. Load RegWriteD=1, MemWriteD=1, JumpD=1 with FlushE=1 and StallE=1
//     -> RegWriteE=0, MemWriteE=0, PCSrcE=0, RdE=0.
//  6. Load RdD=7, then StallE=1 for 3 cycles while D inputs change
//     -> RdE stays 7. Assert rst in cycle 2 of the stall -> all outputs cleared next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared widths, ALU/forwarding/branch codes and the ID/EX payload for the RV32I core.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned FWD_W  = 2;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned RSRC_W = 2;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'b1001;

    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    localparam logic [F3_W-1:0] BR_EQ  = 3'b000;
    localparam logic [F3_W-1:0] BR_NE  = 3'b001;
    localparam logic [F3_W-1:0] BR_LT  = 3'b100;
    localparam logic [F3_W-1:0] BR_GE  = 3'b101;
    localparam logic [F3_W-1:0] BR_LTU = 3'b110;
    localparam logic [F3_W-1:0] BR_GEU = 3'b111;

    // ID/EX pipeline register contents; all-zero is the bubble.
    typedef struct packed {
        logic              reg_write;
        logic [RSRC_W-1:0] result_src;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic              alu_src;
        logic [ALU_W-1:0]  alu_control;
        logic [F3_W-1:0]   funct3;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } idex_t;

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I ALU; unused op codes produce zero.
module alu_core
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0]  src_a,
    input  logic [XLEN-1:0]  src_b,
    input  logic [ALU_W-1:0] alu_control,
    output logic [XLEN-1:0]  alu_result
);

    logic [4:0] shamt;

    assign shamt = src_b[4:0];

    // Operation select; shifts only look at the low five bits of src_b.
    always_comb begin
        alu_result = '0;
        case (alu_control)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_SLL:  alu_result = src_a << shamt;
            ALU_SRL:  alu_result = src_a >> shamt;
            ALU_SRA:  alu_result = XLEN'($signed(src_a) >>> shamt);
            ALU_SLT:  alu_result = XLEN'($signed(src_a) < $signed(src_b));
            ALU_SLTU: alu_result = XLEN'(src_a < src_b);
            default:  alu_result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// ID/EX register plus execute datapath: forwarding, ALU, branch decision and target.
module execute_stage
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              RegWriteD,
    input  logic [1:0]        ResultSrcD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic [3:0]        ALUControlD,
    input  logic [2:0]        funct3D,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [XLEN-1:0]   ResultW,
    input  logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   ALUResultE,
    output logic [XLEN-1:0]   WriteDataE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              PCSrcE,
    output logic              RegWriteE,
    output logic [1:0]        ResultSrcE,
    output logic              MemWriteE,
    output logic [REG_AW-1:0] RdE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [XLEN-1:0]   PCPlus4E
);

    idex_t           idex_d;
    idex_t           idex_q;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            taken;

    // Gather decode-stage signals into the pipeline payload.
    always_comb begin
        idex_d             = '0;
        idex_d.reg_write   = RegWriteD;
        idex_d.result_src  = ResultSrcD;
        idex_d.mem_write   = MemWriteD;
        idex_d.jump        = JumpD;
        idex_d.branch      = BranchD;
        idex_d.alu_src     = ALUSrcD;
        idex_d.alu_control = ALUControlD;
        idex_d.funct3      = funct3D;
        idex_d.rd1         = RD1D;
        idex_d.rd2         = RD2D;
        idex_d.imm         = ImmExtD;
        idex_d.pc          = PCD;
        idex_d.pc_plus4    = PCPlus4D;
        idex_d.rs1         = Rs1D;
        idex_d.rs2         = Rs2D;
        idex_d.rd          = RdD;
    end

    // ID/EX register: reset and flush insert a bubble, flush beats stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else if (FlushE) begin
            idex_q <= '0;
        end else if (!StallE) begin
            idex_q <= idex_d;
        end
    end

    // Forwarding muxes; code 11 falls back to the register value.
    always_comb begin
        src_a      = idex_q.rd1;
        WriteDataE = idex_q.rd2;
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = idex_q.rd1;
        endcase
        case (ForwardBE)
            FWD_WB:  WriteDataE = ResultW;
            FWD_MEM: WriteDataE = ALUResultM;
            default: WriteDataE = idex_q.rd2;
        endcase
    end

    assign src_b = idex_q.alu_src ? idex_q.imm : WriteDataE;

    alu_core u_alu (
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (idex_q.alu_control),
        .alu_result  (ALUResultE)
    );

    // Branch condition compares SrcA against the forwarded rs2 value, never the immediate.
    always_comb begin
        taken = 1'b0;
        case (idex_q.funct3)
            BR_EQ:   taken = (src_a == WriteDataE);
            BR_NE:   taken = (src_a != WriteDataE);
            BR_LT:   taken = ($signed(src_a) <  $signed(WriteDataE));
            BR_GE:   taken = ($signed(src_a) >= $signed(WriteDataE));
            BR_LTU:  taken = (src_a <  WriteDataE);
            BR_GEU:  taken = (src_a >= WriteDataE);
            default: taken = 1'b0;
        endcase
    end

    assign PCSrcE     = idex_q.jump | (idex_q.branch & taken);
    assign PCTargetE  = idex_q.pc + idex_q.imm;
    assign RegWriteE  = idex_q.reg_write;
    assign ResultSrcE = idex_q.result_src;
    assign MemWriteE  = idex_q.mem_write;
    assign RdE        = idex_q.rd;
    assign Rs1E       = idex_q.rs1;
    assign Rs2E       = idex_q.rs2;
    assign PCPlus4E   = idex_q.pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        StallE;
    logic        FlushE;
    logic        RegWriteD;
    logic [1:0]  ResultSrcD;
    logic        MemWriteD;
    logic        JumpD;
    logic        BranchD;
    logic        ALUSrcD;
    logic [3:0]  ALUControlD;
    logic [2:0]  funct3D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ImmExtD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  RdD;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [31:0] ResultW;
    logic [31:0] ALUResultM;
    logic [31:0] ALUResultE;
    logic [31:0] WriteDataE;
    logic [31:0] PCTargetE;
    logic        PCSrcE;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic [4:0]  RdE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [31:0] PCPlus4E;

    int vectors;
    int miscompares;

    execute_stage dut (
        .clk         (clk),
        .rst         (rst),
        .StallE      (StallE),
        .FlushE      (FlushE),
        .RegWriteD   (RegWriteD),
        .ResultSrcD  (ResultSrcD),
        .MemWriteD   (MemWriteD),
        .JumpD       (JumpD),
        .BranchD     (BranchD),
        .ALUSrcD     (ALUSrcD),
        .ALUControlD (ALUControlD),
        .funct3D     (funct3D),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .ImmExtD     (ImmExtD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RdD         (RdD),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .ResultW     (ResultW),
        .ALUResultM  (ALUResultM),
        .ALUResultE  (ALUResultE),
        .WriteDataE  (WriteDataE),
        .PCTargetE   (PCTargetE),
        .PCSrcE      (PCSrcE),
        .RegWriteE   (RegWriteE),
        .ResultSrcE  (ResultSrcE),
        .MemWriteE   (MemWriteE),
        .RdE         (RdE),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .PCPlus4E    (PCPlus4E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        rst = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        RegWriteD = 1'b0; ResultSrcD = 2'b00; MemWriteD = 1'b0; JumpD = 1'b0;
        BranchD = 1'b0; ALUSrcD = 1'b0; ALUControlD = 4'b0000; funct3D = 3'b010;
        RD1D = '0; RD2D = '0; ImmExtD = '0; PCD = '0; PCPlus4D = '0;
        Rs1D = '0; Rs2D = '0; RdD = '0;
        ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = '0; ALUResultM = '0;
    endtask

    // One active edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        RD1D = 32'h1234; RegWriteD = 1'b1; RdD = 5'd3; PCPlus4D = 32'h44;
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (RegWriteE !== 1'b0) begin miscompares++; $display("FAIL reset_regwrite got %b exp 0", RegWriteE); end
        vectors++;
        if (RdE !== 5'd0) begin miscompares++; $display("FAIL reset_rd got %0d exp 0", RdE); end
        vectors++;
        if (PCPlus4E !== 32'h0) begin miscompares++; $display("FAIL reset_pcplus4 got %h exp 0", PCPlus4E); end
        vectors++;
        if (ALUResultE !== 32'h0) begin miscompares++; $display("FAIL reset_alu got %h exp 0", ALUResultE); end
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        clear_inputs();
        RD1D = 32'd5; RD2D = 32'd7; ALUControlD = 4'b0000;
        tick();
        vectors++;
        if (ALUResultE !== 32'd12) begin miscompares++; $display("FAIL add got %h exp 0000000c", ALUResultE); end
        vectors++;
        if (WriteDataE !== 32'd7) begin miscompares++; $display("FAIL add_wdata got %h exp 00000007", WriteDataE); end
        ALUControlD = 4'b0001;
        tick();
        vectors++;
        if (ALUResultE !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL sub got %h exp fffffffe", ALUResultE); end
    endtask

    task automatic test_shift_compare();
        logic [3:0]  ops [7];
        logic [31:0] exps [7];
        ops[0] = 4'b0111; exps[0] = 32'hF800_0000;
        ops[1] = 4'b0110; exps[1] = 32'h0800_0000;
        ops[2] = 4'b0101; exps[2] = 32'h0000_0000;
        ops[3] = 4'b1000; exps[3] = 32'h0000_0001;
        ops[4] = 4'b1001; exps[4] = 32'h0000_0000;
        ops[5] = 4'b0100; exps[5] = 32'h8000_0024;
        ops[6] = 4'b1010; exps[6] = 32'h0000_0000;
        clear_inputs();
        RD1D = 32'h8000_0000; ImmExtD = 32'h24; ALUSrcD = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ALUControlD = ops[i];
            tick();
            vectors++;
            if (ALUResultE !== exps[i]) begin
                miscompares++;
                $display("FAIL alu_op_%b got %h exp %h", ops[i], ALUResultE, exps[i]);
            end
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        RD1D = 32'd1; RD2D = 32'd2; ALUControlD = 4'b0000;
        tick();
        ForwardAE = 2'b10; ALUResultM = 32'h100;
        ForwardBE = 2'b01; ResultW = 32'h23;
        #1;
        vectors++;
        if (ALUResultE !== 32'h123) begin miscompares++; $display("FAIL fwd_alu got %h exp 00000123", ALUResultE); end
        vectors++;
        if (WriteDataE !== 32'h23) begin miscompares++; $display("FAIL fwd_wdata got %h exp 00000023", WriteDataE); end
        ForwardAE = 2'b11; ForwardBE = 2'b11;
        #1;
        vectors++;
        if (ALUResultE !== 32'd3) begin miscompares++; $display("FAIL fwd_11 got %h exp 00000003", ALUResultE); end
        ForwardAE = 2'b00; ForwardBE = 2'b00;
    endtask

    task automatic test_branch();
        logic [2:0] f3s [6];
        logic       exps [6];
        f3s[0] = 3'b100; exps[0] = 1'b1;
        f3s[1] = 3'b110; exps[1] = 1'b0;
        f3s[2] = 3'b000; exps[2] = 1'b0;
        f3s[3] = 3'b001; exps[3] = 1'b1;
        f3s[4] = 3'b111; exps[4] = 1'b1;
        f3s[5] = 3'b010; exps[5] = 1'b0;
        clear_inputs();
        RD1D = 32'hFFFF_FFFF; RD2D = 32'd1; BranchD = 1'b1;
        ALUSrcD = 1'b1; PCD = 32'h1000; ImmExtD = 32'hFFFF_FFF0;
        for (int i = 0; i < 6; i++) begin
            funct3D = f3s[i];
            tick();
            vectors++;
            if (PCSrcE !== exps[i]) begin
                miscompares++;
                $display("FAIL branch_f3_%b got %b exp %b", f3s[i], PCSrcE, exps[i]);
            end
        end
        vectors++;
        if (PCTargetE !== 32'h0000_0FF0) begin miscompares++; $display("FAIL target got %h exp 00000ff0", PCTargetE); end
        BranchD = 1'b0; JumpD = 1'b1; PCD = 32'hFFFF_FFF0; ImmExtD = 32'h20;
        tick();
        vectors++;
        if (PCSrcE !== 1'b1) begin miscompares++; $display("FAIL jump got %b exp 1", PCSrcE); end
        vectors++;
        if (PCTargetE !== 32'h0000_0010) begin miscompares++; $display("FAIL target_wrap got %h exp 00000010", PCTargetE); end
    endtask

    task automatic test_flush();
        clear_inputs();
        RegWriteD = 1'b1; MemWriteD = 1'b1; JumpD = 1'b1; RdD = 5'd9;
        RD1D = 32'd4; RD2D = 32'd4;
        tick();
        vectors++;
        if (RegWriteE !== 1'b1 || RdE !== 5'd9) begin
            miscompares++; $display("FAIL preflush_load got rw=%b rd=%0d exp rw=1 rd=9", RegWriteE, RdE);
        end
        FlushE = 1'b1; StallE = 1'b1;
        tick();
        vectors++;
        if (RegWriteE !== 1'b0) begin miscompares++; $display("FAIL flush_regwrite got %b exp 0", RegWriteE); end
        vectors++;
        if (MemWriteE !== 1'b0) begin miscompares++; $display("FAIL flush_memwrite got %b exp 0", MemWriteE); end
        vectors++;
        if (PCSrcE !== 1'b0) begin miscompares++; $display("FAIL flush_pcsrc got %b exp 0", PCSrcE); end
        vectors++;
        if (RdE !== 5'd0) begin miscompares++; $display("FAIL flush_rd got %0d exp 0", RdE); end
        vectors++;
        if (ALUResultE !== 32'd0) begin miscompares++; $display("FAIL flush_alu got %h exp 0", ALUResultE); end
    endtask

    task automatic test_stall_reset();
        clear_inputs();
        RdD = 5'd7; RegWriteD = 1'b1; PCPlus4D = 32'h88; Rs1D = 5'd2;
        tick();
        vectors++;
        if (RdE !== 5'd7) begin miscompares++; $display("FAIL stall_load got %0d exp 7", RdE); end
        StallE = 1'b1; RdD = 5'd11; Rs1D = 5'd12; PCPlus4D = 32'h99;
        tick();
        vectors++;
        if (RdE !== 5'd7 || Rs1E !== 5'd2 || PCPlus4E !== 32'h88) begin
            miscompares++; $display("FAIL stall_hold got rd=%0d rs1=%0d pc4=%h exp rd=7 rs1=2 pc4=88", RdE, Rs1E, PCPlus4E);
        end
        RdD = 5'd13; rst = 1'b1;
        tick();
        vectors++;
        if (RdE !== 5'd0 || RegWriteE !== 1'b0 || PCPlus4E !== 32'h0 || Rs1E !== 5'd0) begin
            miscompares++; $display("FAIL stall_reset got rd=%0d rw=%b pc4=%h rs1=%0d exp all 0", RdE, RegWriteE, PCPlus4E, Rs1E);
        end
        rst = 1'b0; StallE = 1'b0; RdD = 5'd9;
        tick();
        vectors++;
        if (RdE !== 5'd9 || RegWriteE !== 1'b1) begin
            miscompares++; $display("FAIL post_reset_load got rd=%0d rw=%b exp rd=9 rw=1", RdE, RegWriteE);
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        RD1D = 32'hF0F0_0000; RD2D = 32'h0FF0_0000; ALUControlD = 4'b0011;
        tick();
        vectors++;
        if (ALUResultE !== 32'h00F0_0000) begin miscompares++; $display("FAIL and got %h exp 00f00000", ALUResultE); end
        ALUControlD = 4'b0010;
        tick();
        vectors++;
        if (ALUResultE !== 32'hFF00_0000) begin miscompares++; $display("FAIL xor got %h exp ff000000", ALUResultE); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clear_inputs();
        test_reset();
        test_add_sub();
        test_shift_compare();
        test_forwarding();
        test_branch();
        test_flush();
        test_stall_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
